regfile_scoreboard: RTL and testbench

//  Parametrised register file for the single-cycle/pipelined RISC-V datapath: 2 async read

---
 rtl/regfile_scoreboard.sv | 110 +++++++++++
 tb/tb_regfile_scoreboard.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port, optional x0,
// same-cycle write bypass and a per-register busy scoreboard for RAW hazard stalls.
module regfile_scoreboard #(
  parameter int unsigned W        = 32,
  parameter int unsigned AW       = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] Read1,
  input  logic [AW-1:0] Read2,
  output logic [W-1:0]  Data1,
  output logic [W-1:0]  Data2,
  output logic          Busy1,
  output logic          Busy2,
  input  logic [AW-1:0] WriteReg,
  input  logic [W-1:0]  WriteData,
  input  logic          RegWrite,
  input  logic          Reserve,
  input  logic [AW-1:0] ReserveReg,
  output logic [AW:0]   Pending,
  output logic          ResErr
);

  localparam int unsigned N = 1 << AW;

  logic [W-1:0] regs_r [N];
  logic [N-1:0] busy_r;
  logic [AW:0]  pending_r;
  logic         res_err_r;

  logic wr_s;
  logic rsv_s;
  logic inc_s;
  logic dec_s;
  logic err_s;

  // Returns {busy, data} seen by one read port, bypassing an in-flight write.
  function automatic logic [W:0] read_port(
    input logic [AW-1:0] addr,
    input logic [W-1:0]  mem_val,
    input logic          busy_val,
    input logic          wr,
    input logic [AW-1:0] waddr,
    input logic [W-1:0]  wdata
  );
    logic [W:0] res;
    res = {busy_val, mem_val};
    if (ZERO_REG && (addr == {AW{1'b0}})) begin
      res = {1'b0, {W{1'b0}}};
    end else if (BYPASS && wr && (waddr == addr)) begin
      res = {1'b0, wdata};
    end else begin
      res = {busy_val, mem_val};
    end
    return res;
  endfunction

  // Effective write/reserve qualifiers and scoreboard bookkeeping terms.
  always_comb begin
    wr_s  = RegWrite & ~reset & ~(ZERO_REG & (WriteReg == {AW{1'b0}}));
    rsv_s = Reserve & ~reset & ~(ZERO_REG & (ReserveReg == {AW{1'b0}}));
    inc_s = rsv_s & ~busy_r[ReserveReg];
    // A release cancelled by a same-register reserve leaves the count untouched.
    dec_s = wr_s & busy_r[WriteReg] & ~(rsv_s & (ReserveReg == WriteReg));
    err_s = rsv_s & busy_r[ReserveReg] & ~(wr_s & (WriteReg == ReserveReg));
  end

  // Read port muxing.
  always_comb begin
    {Busy1, Data1} = read_port(Read1, regs_r[Read1], busy_r[Read1], wr_s, WriteReg, WriteData);
    {Busy2, Data2} = read_port(Read2, regs_r[Read2], busy_r[Read2], wr_s, WriteReg, WriteData);
  end

  // Register storage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        regs_r[i] <= {W{1'b0}};
      end
    end else if (wr_s) begin
      regs_r[WriteReg] <= WriteData;
    end
  end

  // Scoreboard: reserve is applied after release so it wins on the same register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_r    <= {N{1'b0}};
      pending_r <= {(AW+1){1'b0}};
      res_err_r <= 1'b0;
    end else begin
      if (wr_s) begin
        busy_r[WriteReg] <= 1'b0;
      end
      if (rsv_s) begin
        busy_r[ReserveReg] <= 1'b1;
      end
      pending_r <= pending_r + {{AW{1'b0}}, inc_s} - {{AW{1'b0}}, dec_s};
      if (err_s) begin
        res_err_r <= 1'b1;
      end
    end
  end

  assign Pending = pending_r;
  assign ResErr  = res_err_r;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench: two 32x32 register files (x0+bypass, plain) checked every cycle against a
// behavioural model, plus a small 8x16 instance for scoreboard saturation behaviour.
module tb_regfile_scoreboard;

  logic        clock;
  logic        reset;
  logic [4:0]  rd1, rd2, wreg, rsvreg;
  logic [31:0] wdata;
  logic        regwrite, reserve;

  logic [31:0] a_d1, a_d2, b_d1, b_d2;
  logic        a_b1, a_b2, b_b1, b_b2, a_err, b_err;
  logic [5:0]  a_pend, b_pend;

  logic [2:0]  c_rd1, c_rd2, c_wreg, c_rsvreg;
  logic [15:0] c_wdata, c_d1, c_d2;
  logic        c_we, c_rsv, c_b1, c_b2, c_err;
  logic [3:0]  c_pend;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  regfile_scoreboard #(.W(32), .AW(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
    .clock(clock), .reset(reset), .Read1(rd1), .Read2(rd2), .Data1(a_d1), .Data2(a_d2),
    .Busy1(a_b1), .Busy2(a_b2), .WriteReg(wreg), .WriteData(wdata), .RegWrite(regwrite),
    .Reserve(reserve), .ReserveReg(rsvreg), .Pending(a_pend), .ResErr(a_err));

  regfile_scoreboard #(.W(32), .AW(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .clock(clock), .reset(reset), .Read1(rd1), .Read2(rd2), .Data1(b_d1), .Data2(b_d2),
    .Busy1(b_b1), .Busy2(b_b2), .WriteReg(wreg), .WriteData(wdata), .RegWrite(regwrite),
    .Reserve(reserve), .ReserveReg(rsvreg), .Pending(b_pend), .ResErr(b_err));

  regfile_scoreboard #(.W(16), .AW(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_c (
    .clock(clock), .reset(reset), .Read1(c_rd1), .Read2(c_rd2), .Data1(c_d1), .Data2(c_d2),
    .Busy1(c_b1), .Busy2(c_b2), .WriteReg(c_wreg), .WriteData(c_wdata), .RegWrite(c_we),
    .Reserve(c_rsv), .ReserveReg(c_rsvreg), .Pending(c_pend), .ResErr(c_err));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: index 0 = x0 hardwired with bypass, index 1 = plain without bypass.
  logic [31:0] m_mem  [2][32];
  logic        m_busy [2][32];
  logic        m_err  [2];

  function automatic bit eff(int i, logic en, logic [4:0] a);
    return en && !reset && !(i == 0 && a == 5'd0);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_err[i] <= 1'b0;
        for (int j = 0; j < 32; j++) begin
          m_mem[i][j]  <= 32'd0;
          m_busy[i][j] <= 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (eff(i, reserve, rsvreg) && m_busy[i][rsvreg] && !(eff(i, regwrite, wreg) && wreg == rsvreg))
          m_err[i] <= 1'b1;
        if (eff(i, regwrite, wreg)) begin
          m_mem[i][wreg]  <= wdata;
          m_busy[i][wreg] <= 1'b0;
        end
        if (eff(i, reserve, rsvreg))
          m_busy[i][rsvreg] <= 1'b1;
      end
    end
  end

  function automatic logic [31:0] exp_data(int i, logic [4:0] a);
    if (reset || (i == 0 && a == 5'd0)) return 32'd0;
    if (i == 0 && eff(0, regwrite, wreg) && wreg == a) return wdata;
    return m_mem[i][a];
  endfunction

  function automatic logic [31:0] exp_busy(int i, logic [4:0] a);
    if (reset || (i == 0 && a == 5'd0)) return 32'd0;
    if (i == 0 && eff(0, regwrite, wreg) && wreg == a) return 32'd0;
    return {31'd0, m_busy[i][a]};
  endfunction

  function automatic logic [31:0] exp_pend(int i);
    int n = 0;
    for (int j = 0; j < 32; j++) n += int'(m_busy[i][j]);
    return n;
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      check("A.Data1", a_d1, exp_data(0, rd1));
      check("A.Data2", a_d2, exp_data(0, rd2));
      check("A.Busy1", {31'd0, a_b1}, exp_busy(0, rd1));
      check("A.Busy2", {31'd0, a_b2}, exp_busy(0, rd2));
      check("A.Pending", {26'd0, a_pend}, exp_pend(0));
      check("A.ResErr", {31'd0, a_err}, {31'd0, m_err[0]});
      check("B.Data1", b_d1, exp_data(1, rd1));
      check("B.Data2", b_d2, exp_data(1, rd2));
      check("B.Busy1", {31'd0, b_b1}, exp_busy(1, rd1));
      check("B.Busy2", {31'd0, b_b2}, exp_busy(1, rd2));
      check("B.Pending", {26'd0, b_pend}, exp_pend(1));
      check("B.ResErr", {31'd0, b_err}, {31'd0, m_err[1]});
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    rd1 = 5'd0; rd2 = 5'd0; wreg = 5'd0; rsvreg = 5'd0; wdata = 32'd0;
    regwrite = 1'b0; reserve = 1'b0;
    c_rd1 = 3'd0; c_rd2 = 3'd0; c_wreg = 3'd0; c_rsvreg = 3'd0; c_wdata = 16'd0;
    c_we = 1'b0; c_rsv = 1'b0;
    step(); step();
    reset = 1'b0;
    chk_en = 1'b1;
    #1;
    check("reset.A.Pending", {26'd0, a_pend}, 32'd0);
    check("reset.A.Data1", a_d1, 32'd0);

    // Same-cycle bypass versus post-edge visibility.
    regwrite = 1'b1; wreg = 5'd7; wdata = 32'd5; rd1 = 5'd7;
    #1;
    check("byp.A.Data1", a_d1, 32'd5);
    check("nobyp.B.Data1", b_d1, 32'd0);
    step();
    regwrite = 1'b0;
    #1;
    check("nobyp.B.Data1.after", b_d1, 32'd5);

    // Hardwired zero register ignores writes and reserves.
    regwrite = 1'b1; wreg = 5'd0; wdata = 32'hFFFF_FFFF; reserve = 1'b1; rsvreg = 5'd0; rd1 = 5'd0;
    #1;
    check("x0.A.Data1", a_d1, 32'd0);
    check("x0.A.Busy1", {31'd0, a_b1}, 32'd0);
    step();
    regwrite = 1'b0; reserve = 1'b0;
    #1;
    check("x0.A.Pending", {26'd0, a_pend}, 32'd0);
    check("x0.B.Data1", b_d1, 32'hFFFF_FFFF);
    check("x0.B.Pending", {26'd0, b_pend}, 32'd1);
    regwrite = 1'b1; wreg = 5'd0; wdata = 32'd0;
    step();
    regwrite = 1'b0;

    // Reserve then release with bypassed result.
    reserve = 1'b1; rsvreg = 5'd10; rd1 = 5'd10;
    step();
    reserve = 1'b0;
    #1;
    check("rsv.A.Busy1", {31'd0, a_b1}, 32'd1);
    check("rsv.A.Pending", {26'd0, a_pend}, 32'd1);
    regwrite = 1'b1; wreg = 5'd10; wdata = 32'd15;
    #1;
    check("rel.A.Busy1", {31'd0, a_b1}, 32'd0);
    check("rel.A.Data1", a_d1, 32'd15);
    check("rel.B.Busy1", {31'd0, b_b1}, 32'd1);
    step();
    regwrite = 1'b0;
    #1;
    check("rel.A.Pending", {26'd0, a_pend}, 32'd0);

    // Release + re-reserve on the same register, then a genuine double reserve.
    reserve = 1'b1; rsvreg = 5'd3; rd1 = 5'd3;
    step();
    regwrite = 1'b1; wreg = 5'd3; wdata = 32'd9;
    step();
    regwrite = 1'b0; reserve = 1'b0;
    #1;
    check("same.A.Busy1", {31'd0, a_b1}, 32'd1);
    check("same.A.Pending", {26'd0, a_pend}, 32'd1);
    check("same.A.ResErr", {31'd0, a_err}, 32'd0);
    reserve = 1'b1;
    step();
    reserve = 1'b0;
    #1;
    check("dbl.A.ResErr", {31'd0, a_err}, 32'd1);
    check("dbl.A.Pending", {26'd0, a_pend}, 32'd1);
    regwrite = 1'b1; wreg = 5'd3;
    step();
    regwrite = 1'b0;
    #1;
    check("dbl.A.Pending.rel", {26'd0, a_pend}, 32'd0);
    check("dbl.A.ResErr.sticky", {31'd0, a_err}, 32'd1);

    // Release and reserve of different registers in one edge.
    reserve = 1'b1; rsvreg = 5'd4; regwrite = 1'b1; wreg = 5'd5; wdata = 32'h1234;
    rd1 = 5'd4; rd2 = 5'd5;
    step();
    reserve = 1'b0; regwrite = 1'b0;
    #1;
    check("diff.A.Pending", {26'd0, a_pend}, 32'd1);
    check("diff.A.Data2", a_d2, 32'h1234);

    // Mixed traffic, checked cycle-by-cycle against the model.
    for (int i = 0; i < 24; i++) begin
      regwrite = i[0];
      wreg     = 5'((i * 5 + 3) % 32);
      wdata    = 32'hA5A5_0000 + 32'(i);
      reserve  = (i % 3) != 0;
      rsvreg   = 5'((i * 7 + 1) % 32);
      rd1      = (i % 2 == 1) ? wreg : 5'((i * 3) % 32);
      rd2      = rsvreg;
      step();
    end
    regwrite = 1'b0; reserve = 1'b0;

    // Asynchronous reset in mid-cycle clears everything immediately.
    regwrite = 1'b1; wreg = 5'd7; wdata = 32'd5; rd1 = 5'd7; rd2 = 5'd7;
    step();
    regwrite = 1'b0;
    #1;
    check("pre.A.Data1", a_d1, 32'd5);
    check("pre.A.ResErr", {31'd0, a_err}, 32'd1);
    reset = 1'b1;
    #1;
    check("arst.A.Data1", a_d1, 32'd0);
    check("arst.A.Busy1", {31'd0, a_b1}, 32'd0);
    check("arst.A.Pending", {26'd0, a_pend}, 32'd0);
    check("arst.A.ResErr", {31'd0, a_err}, 32'd0);
    check("arst.B.Data2", b_d2, 32'd0);
    reset = 1'b0;
    step();

    // Small instance: fill every non-zero register, then drain without wrap.
    c_rsv = 1'b1; c_rsvreg = 3'd0;
    step();
    check("c.x0.Pending", {28'd0, c_pend}, 32'd0);
    for (int k = 1; k < 8; k++) begin
      c_rsvreg = 3'(k); c_rd1 = 3'(k);
      step();
      check("c.fill.Pending", {28'd0, c_pend}, 32'(k));
      c_rsv = (k < 7);
      #1;
      check("c.fill.Busy1", {31'd0, c_b1}, 32'd1);
    end
    c_rsv = 1'b0;
    for (int k = 1; k < 8; k++) begin
      c_we = 1'b1; c_wreg = 3'(k); c_wdata = 16'(k * 16'h0111);
      step();
      check("c.drain.Pending", {28'd0, c_pend}, 32'(7 - k));
    end
    c_wreg = 3'd2; c_wdata = 16'h0222;
    step();
    c_we = 1'b0; c_rd1 = 3'd5;
    #1;
    check("c.nowrap.Pending", {28'd0, c_pend}, 32'd0);
    check("c.ResErr", {31'd0, c_err}, 32'd0);
    check("c.Data1", {16'd0, c_d1}, 32'h0555);
    check("c.Busy1", {31'd0, c_b1}, 32'd0);
    check("c.x0.Data2", {16'd0, c_d2}, 32'd0);
    check("c.x0.Busy2", {31'd0, c_b2}, 32'd0);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
